// File: rtl/cache_mem_responder_pkg.sv
// Package cache_def
//   Shared types for the cache controller <-> memory interface, plus the
//   memory responder's FSM encoding and line geometry constants.
//   mem_req_type  : {addr[31:0], data[255:0], rw (1 = write), valid}  290 bits
//   mem_data_type : {data[255:0], ready}                              257 bits
package cache_def;

    localparam int LINE_BITS  = 256;
    localparam int LINE_BYTES = 32;
    localparam int LAT_W      = 8;   // latency counter width, covers 1..255

    typedef struct packed {
        logic [31:0]          addr;
        logic [LINE_BITS-1:0] data;
        logic                 rw;
        logic                 valid;
    } mem_req_type;

    typedef struct packed {
        logic [LINE_BITS-1:0] data;
        logic                 ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        MR_IDLE,
        MR_WAIT,
        MR_RESP
    } mem_resp_state_e;

endpackage

// File: rtl/mem_line_ram.sv
// mem_line_ram
//   Single-port 2**LINE_AW x 256-bit line store with synchronous read and
//   write enable. No reset; contents persist across controller resets.
//   clk    : clock
//   en     : access enable (read or write this edge)
//   we     : 1 = write wdata to addr, 0 = read addr into rdata
//   addr   : line index
//   wdata  : line to write
//   rdata  : registered read data; only updated by reads, held otherwise
module mem_line_ram
    import cache_def::*;
#(
    parameter int LINE_AW = 10
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [LINE_AW-1:0]   addr,
    input  logic [LINE_BITS-1:0] wdata,
    output logic [LINE_BITS-1:0] rdata
);

    logic [LINE_BITS-1:0] mem_array [2**LINE_AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_array[addr] <= wdata;
            end else begin
                rdata <= mem_array[addr];
            end
        end
    end

endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder
//   Memory-side responder: accepts one full-line read or write at a time,
//   holds it for READ_LAT / WRITE_LAT cycles and completes it with a
//   single-cycle ready pulse. Backed by an on-chip line RAM.
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset (aborts any in-flight request)
//   mem_req  : request {addr, data, rw, valid}
//   mem_data : response {data, ready}
//   busy     : high from the cycle after accept through the ready cycle
//   addr_err : pulses with ready when the request address was out of range
module cache_mem_responder
    import cache_def::*;
#(
    parameter int LINE_AW   = 10,
    parameter int ADDR_LSB  = 5,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  mem_req_type  mem_req,
    output mem_data_type mem_data,
    output logic         busy,
    output logic         addr_err
);

    localparam int TAG_LSB = ADDR_LSB + LINE_AW;

    // Elaboration-time parameter checks
    if (READ_LAT < 1 || READ_LAT > 255) begin : g_read_lat_chk
        $error("cache_mem_responder: READ_LAT must be in 1..255");
    end
    if (WRITE_LAT < 1 || WRITE_LAT > 255) begin : g_write_lat_chk
        $error("cache_mem_responder: WRITE_LAT must be in 1..255");
    end
    if (TAG_LSB >= 32) begin : g_addr_chk
        $error("cache_mem_responder: ADDR_LSB + LINE_AW must be below 32");
    end

    mem_resp_state_e      state_reg, state_next;
    logic [LAT_W-1:0]     cnt_reg, cnt_next;
    logic [LINE_AW-1:0]   line_reg;
    logic [LINE_BITS-1:0] wdata_reg;
    logic                 rw_reg;
    logic                 err_reg;
    logic [LINE_BITS-1:0] resp_data_reg;

    // Request decode
    logic [LINE_AW-1:0]   req_line;
    logic                 req_err;
    logic [LAT_W-1:0]     req_lat;
    logic                 unused_addr_bits;

    assign req_line         = mem_req.addr[TAG_LSB-1:ADDR_LSB];
    assign req_err          = |mem_req.addr[31:TAG_LSB];
    assign req_lat          = mem_req.rw ? LAT_W'(WRITE_LAT) : LAT_W'(READ_LAT);
    // Byte offset within the line is meaningless for full-line accesses
    assign unused_addr_bits = ^mem_req.addr[ADDR_LSB-1:0];

    // FSM next-state and latency counter
    logic enter_resp;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        enter_resp = 1'b0;
        case (state_reg)
            MR_IDLE: begin
                if (mem_req.valid) begin
                    if (req_lat == LAT_W'(1)) begin
                        state_next = MR_RESP;
                        enter_resp = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        state_next = MR_WAIT;
                        cnt_next   = req_lat - LAT_W'(1);
                    end
                end
            end
            MR_WAIT: begin
                cnt_next = cnt_reg - LAT_W'(1);
                if (cnt_reg == LAT_W'(1)) begin
                    state_next = MR_RESP;
                    enter_resp = 1'b1;
                end
            end
            MR_RESP: begin
                state_next = MR_IDLE;
            end
            default: begin
                state_next = MR_IDLE;
            end
        endcase
    end

    // RAM port: the access is issued on the edge that enters RESP. With a
    // one-cycle latency that edge is the accept edge itself, so the live
    // request is used instead of the (not yet loaded) latched copy.
    logic                 in_idle;
    logic                 cur_err;
    logic                 ram_en;
    logic                 ram_we;
    logic [LINE_AW-1:0]   ram_addr;
    logic [LINE_BITS-1:0] ram_wdata;
    logic [LINE_BITS-1:0] ram_rdata;

    assign in_idle   = (state_reg == MR_IDLE);
    assign cur_err   = in_idle ? req_err      : err_reg;
    assign ram_we    = in_idle ? mem_req.rw   : rw_reg;
    assign ram_addr  = in_idle ? req_line     : line_reg;
    assign ram_wdata = in_idle ? mem_req.data : wdata_reg;
    // Reset on the committing edge discards the write; out-of-range never touches the array
    assign ram_en    = enter_resp && !cur_err && !rst;

    mem_line_ram #(
        .LINE_AW (LINE_AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // State, counter and request latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= MR_IDLE;
            cnt_reg       <= '0;
            line_reg      <= '0;
            wdata_reg     <= '0;
            rw_reg        <= 1'b0;
            err_reg       <= 1'b0;
            resp_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (in_idle && mem_req.valid) begin
                line_reg  <= req_line;
                wdata_reg <= mem_req.data;
                rw_reg    <= mem_req.rw;
                err_reg   <= req_err;
            end
            // Keep the last read response visible until the next read completes
            if (state_reg == MR_RESP && !rw_reg) begin
                resp_data_reg <= err_reg ? '0 : ram_rdata;
            end
        end
    end

    // Outputs
    logic resp_read;

    assign resp_read      = (state_reg == MR_RESP) && !rw_reg;
    assign mem_data.ready = (state_reg == MR_RESP);
    assign mem_data.data  = resp_read ? (err_reg ? '0 : ram_rdata) : resp_data_reg;
    assign busy           = !in_idle;
    assign addr_err       = (state_reg == MR_RESP) && err_reg;

endmodule
